// File: rtl/safety_fault_if.sv
// Signal bundle between the safety fault controller and the system controller / monitors.
// The master side drives the alarms, the mask and the clear request. The slave side is the controller.
interface safety_fault_if #(
  parameter int unsigned N_ALARMS = 5
);
  logic [N_ALARMS-1:0] alarm_in;
  logic [N_ALARMS-1:0] alarm_mask_i;
  logic                clr_req_i;
  logic                clr_ack_o;
  logic                fault_alarm_o;
  logic [N_ALARMS-1:0] fault_code_o;
  logic                safe_state_req_o;
  logic [2:0]          state_o;
  logic [1:0]          recov_cnt_o;

  modport master (
    output alarm_in, alarm_mask_i, clr_req_i,
    input  clr_ack_o, fault_alarm_o, fault_code_o, safe_state_req_o, state_o, recov_cnt_o
  );

  modport slave (
    input  alarm_in, alarm_mask_i, clr_req_i,
    output clr_ack_o, fault_alarm_o, fault_code_o, safe_state_req_o, state_o, recov_cnt_o
  );
endinterface

// File: rtl/safety_fault_controller.sv
// Filters the active-low alarm lines for persistence and latches a sticky fault code.
// Escalates unacknowledged faults to a safe-state request and locks out after repeated recoveries.
module safety_fault_controller #(
  parameter int unsigned N_ALARMS       = 5,
  parameter int unsigned PERSIST_CYCLES = 4,
  parameter int unsigned ESC_TIMEOUT    = 1024,
  parameter int unsigned MAX_RECOVERY   = 3
) (
  input  logic          clk,
  input  logic          rst,
  safety_fault_if.slave bus
);
  // Clear handshake: clr_req_i is a level request. It is accepted only in FAULT/SAFE
  // and only in a cycle with no unmasked active alarm. Acceptance is answered by
  // a one-cycle clr_ack_o on the next edge. The state leaves FAULT/SAFE on that same
  // edge, so a request that stays high is acknowledged once per fault episode.

  typedef enum logic [2:0] {
    ST_OK     = 3'd0,
    ST_FILTER = 3'd1,
    ST_FAULT  = 3'd2,
    ST_SAFE   = 3'd3,
    ST_LOCKED = 3'd4
  } state_t;

  localparam logic [7:0]  PCNT_LAST = 8'(PERSIST_CYCLES - 1);
  localparam logic [15:0] TMR_LAST  = 16'(ESC_TIMEOUT - 1);
  localparam logic [1:0]  RECOV_MAX = 2'(MAX_RECOVERY);

  logic [N_ALARMS-1:0] act;
  logic                any_act;

  state_t              state_q, state_d;
  logic [7:0]          pcnt_q, pcnt_d;
  logic [15:0]         tmr_q, tmr_d;
  logic [1:0]          recov_q, recov_d;
  logic [N_ALARMS-1:0] code_q, code_d;
  logic                clr_acc;

  logic                alarm_q, alarm_d;
  logic                safe_q, safe_d;
  logic                ack_q;

  assign act     = ~bus.alarm_in & ~bus.alarm_mask_i;
  assign any_act = |act;

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) state_q <= ST_OK;
    else      state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tmr_d   = tmr_q;
    recov_d = recov_q;
    code_d  = code_q;
    clr_acc = 1'b0;
    case (state_q)
      ST_OK: begin
        if (any_act) begin
          state_d = ST_FILTER;
          pcnt_d  = 8'd1;
          code_d  = code_q | act;
        end
      end
      ST_FILTER: begin
        if (!any_act) begin
          // Transient: the alarm did not persist, so forget what it contributed.
          state_d = ST_OK;
          pcnt_d  = '0;
          code_d  = '0;
        end else begin
          code_d = code_q | act;
          if (pcnt_q >= PCNT_LAST) begin
            state_d = ST_FAULT;
            pcnt_d  = '0;
            tmr_d   = '0;
          end else begin
            pcnt_d = pcnt_q + 8'd1;
          end
        end
      end
      ST_FAULT, ST_SAFE: begin
        code_d = code_q | act;
        if (bus.clr_req_i && !any_act) begin
          // An accepted clear takes priority over a timer expiry on the same edge.
          clr_acc = 1'b1;
          tmr_d   = '0;
          if (recov_q == RECOV_MAX) begin
            state_d = ST_LOCKED;
            code_d  = '1;
          end else begin
            state_d = ST_OK;
            recov_d = recov_q + 2'd1;
            code_d  = '0;
          end
        end else if (state_q == ST_FAULT) begin
          if (tmr_q == TMR_LAST) state_d = ST_SAFE;
          else                   tmr_d   = tmr_q + 16'd1;
        end
      end
      ST_LOCKED: code_d = '1;
      default: begin
        state_d = ST_OK;
        pcnt_d  = '0;
        tmr_d   = '0;
        code_d  = '0;
      end
    endcase
  end

  always_comb begin : output_dec
    alarm_d = 1'b1;
    safe_d  = 1'b0;
    case (state_d)
      ST_FAULT:  alarm_d = 1'b0;
      ST_SAFE,
      ST_LOCKED: begin
        alarm_d = 1'b0;
        safe_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin : data_reg
    if (!rst) begin
      pcnt_q  <= '0;
      tmr_q   <= '0;
      recov_q <= '0;
      code_q  <= '0;
      alarm_q <= 1'b1;
      safe_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      tmr_q   <= tmr_d;
      recov_q <= recov_d;
      code_q  <= code_d;
      alarm_q <= alarm_d;
      safe_q  <= safe_d;
      ack_q   <= clr_acc;
    end
  end

  assign bus.clr_ack_o        = ack_q;
  assign bus.fault_alarm_o    = alarm_q;
  assign bus.fault_code_o     = code_q;
  assign bus.safe_state_req_o = safe_q;
  assign bus.state_o          = state_q;
  assign bus.recov_cnt_o      = recov_q;
endmodule
